// File: rtl/mblk_scan_addr_gen_if.sv
// Address stream interface of mblk_scan_addr_gen: one pixel address per
// valid/ready handshake, with frame coordinates and block position flags.
// The master drives the address stream, the slave returns iAddrReady.
interface mblk_scan_addr_gen_if #(
  parameter int P_DIM_W  = 12,
  parameter int P_ADDR_W = 24
);
  logic                oAddrValid;
  logic                iAddrReady;
  logic [P_ADDR_W-1:0] oAddr;
  logic [P_DIM_W-1:0]  oX;
  logic [P_DIM_W-1:0]  oY;
  logic                oFirstInBlk;
  logic                oLastInBlk;
  logic                oLastInFrame;

  modport master (
    output oAddrValid, oAddr, oX, oY, oFirstInBlk, oLastInBlk, oLastInFrame,
    input  iAddrReady
  );

  modport slave (
    input  oAddrValid, oAddr, oX, oY, oFirstInBlk, oLastInBlk, oLastInFrame,
    output iAddrReady
  );
endinterface

// File: rtl/mblk_scan_addr_gen.sv
// Macroblock scan address generator. Walks a raster-stored frame in
// macroblock order (blocks raster across the frame, pixels raster inside
// each block) and emits one pixel address per handshake.
// Optional feature macro: MBLK_CLIP_EN -- when defined, partial blocks at
// the right/bottom edges are emitted clipped to the frame; when undefined,
// only whole blocks are emitted.
// Addresses are built incrementally from row-base registers (adders only).
// Assumes P_DIM_W >= 8 and P_ADDR_W > P_DIM_W.
module mblk_scan_addr_gen #(
  parameter int P_DIM_W  = 12,
  parameter int P_ADDR_W = 24
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic [1:0]          iMbType,
  input  logic [P_DIM_W-1:0]  iFrameW,
  input  logic [P_DIM_W-1:0]  iFrameH,
  input  logic [P_ADDR_W-1:0] iStride,
  input  logic [P_ADDR_W-1:0] iBaseAddr,
  output logic                oBusy,
  output logic                oDone,
  mblk_scan_addr_gen_if.master addr_if
);

  // Dimension arithmetic is done two bits wider so block-edge sums never wrap.
  localparam int LP_EXT_W = P_DIM_W + 2;
  localparam logic [LP_EXT_W-1:0] LP_ONE_EXT  = 1;
  localparam logic [P_DIM_W-1:0]  LP_ONE_DIM  = 1;
  localparam logic [P_ADDR_W-1:0] LP_ONE_ADDR = 1;
  localparam logic [5:0]          LP_ONE_OFS  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched frame configuration
  logic [6:0]          r_blk_sz;
  logic [P_DIM_W-1:0]  r_frame_w;
  logic [P_DIM_W-1:0]  r_frame_h;
  logic [P_ADDR_W-1:0] r_stride;

  // Scan position
  logic [P_DIM_W-1:0]  r_blk_x0;      // x of current block's left column
  logic [P_DIM_W-1:0]  r_blk_y0;      // y of current block row's top line
  logic [5:0]          r_px;          // x offset inside block
  logic [5:0]          r_py;          // y offset inside block
  logic [P_DIM_W-1:0]  r_x;
  logic [P_DIM_W-1:0]  r_y;
  logic [P_ADDR_W-1:0] r_addr;
  logic [P_ADDR_W-1:0] r_row_base;    // base + r_y * stride
  logic [P_ADDR_W-1:0] r_blkrow_base; // base + r_blk_y0 * stride

  // Start-time decode
  logic [6:0]          w_start_sz;
  logic [LP_EXT_W-1:0] w_start_sz_ext;
  logic                w_start_zero;

  // Current-block geometry
  logic [LP_EXT_W-1:0] w_blk_ext;
  logic [LP_EXT_W-1:0] w_bx0_ext;
  logic [LP_EXT_W-1:0] w_by0_ext;
  logic [LP_EXT_W-1:0] w_fw_ext;
  logic [LP_EXT_W-1:0] w_fh_ext;
  logic [LP_EXT_W-1:0] w_bw;
  logic [LP_EXT_W-1:0] w_bh;
  logic                w_last_bcol;
  logic                w_last_brow;
  logic                w_px_last;
  logic                w_py_last;
  logic                w_run;
  logic                w_fire;
  logic                w_last_frame;

  logic [P_DIM_W-1:0]  w_blk_dim;
  logic [P_DIM_W-1:0]  w_bx_next;
  logic [P_ADDR_W-1:0] w_row_next;

  assign w_start_sz_ext = {{(LP_EXT_W-7){1'b0}}, w_start_sz};
  assign w_blk_ext      = {{(LP_EXT_W-7){1'b0}}, r_blk_sz};
  assign w_blk_dim      = {{(P_DIM_W-7){1'b0}}, r_blk_sz};
  assign w_bx0_ext      = {2'b00, r_blk_x0};
  assign w_by0_ext      = {2'b00, r_blk_y0};
  assign w_fw_ext       = {2'b00, r_frame_w};
  assign w_fh_ext       = {2'b00, r_frame_h};

`ifdef MBLK_CLIP_EN
  // Edge blocks shrink to whatever remains of the frame.
  logic [LP_EXT_W-1:0] w_rem_w;
  logic [LP_EXT_W-1:0] w_rem_h;
  assign w_rem_w      = w_fw_ext - w_bx0_ext;
  assign w_rem_h      = w_fh_ext - w_by0_ext;
  assign w_bw         = (w_rem_w < w_blk_ext) ? w_rem_w : w_blk_ext;
  assign w_bh         = (w_rem_h < w_blk_ext) ? w_rem_h : w_blk_ext;
  assign w_last_bcol  = (w_bx0_ext + w_blk_ext) >= w_fw_ext;
  assign w_last_brow  = (w_by0_ext + w_blk_ext) >= w_fh_ext;
  assign w_start_zero = (iFrameW == '0) || (iFrameH == '0);
`else
  // Only whole blocks: a block column/row is last when the next one would
  // not fit entirely inside the frame.
  assign w_bw         = w_blk_ext;
  assign w_bh         = w_blk_ext;
  assign w_last_bcol  = (w_bx0_ext + (w_blk_ext << 1)) > w_fw_ext;
  assign w_last_brow  = (w_by0_ext + (w_blk_ext << 1)) > w_fh_ext;
  assign w_start_zero = ({2'b00, iFrameW} < w_start_sz_ext) ||
                        ({2'b00, iFrameH} < w_start_sz_ext);
`endif

  assign w_px_last    = ({{(LP_EXT_W-6){1'b0}}, r_px} == (w_bw - LP_ONE_EXT));
  assign w_py_last    = ({{(LP_EXT_W-6){1'b0}}, r_py} == (w_bh - LP_ONE_EXT));
  assign w_run        = (r_state == S_RUN);
  assign w_fire       = w_run && addr_if.iAddrReady;
  assign w_last_frame = w_px_last && w_py_last && w_last_bcol && w_last_brow;

  assign w_bx_next  = r_blk_x0 + w_blk_dim;
  assign w_row_next = r_row_base + r_stride;

  // Decode the requested block edge length.
  always_comb begin
    w_start_sz = 7'd8;
    case (iMbType)
      2'b00:   w_start_sz = 7'd8;
      2'b11:   w_start_sz = 7'd16;
      2'b10:   w_start_sz = 7'd32;
      default: w_start_sz = 7'd64;
    endcase
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: start -> RUN (or straight to DONE for an empty frame),
  // final handshake -> DONE, DONE lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_state_next = w_start_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_fire && w_last_frame) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch frame configuration on an accepted start; ignored while busy.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_blk_sz  <= 7'd8;
      r_frame_w <= '0;
      r_frame_h <= '0;
      r_stride  <= '0;
    end else if ((r_state == S_IDLE) && iStart) begin
      r_blk_sz  <= w_start_sz;
      r_frame_w <= iFrameW;
      r_frame_h <= iFrameH;
      r_stride  <= iStride;
    end
  end

  // Scan position and address: step x inside block, then next block line,
  // then next block right, then next block row down.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_blk_x0      <= '0;
      r_blk_y0      <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_row_base    <= '0;
      r_blkrow_base <= '0;
    end else if ((r_state == S_IDLE) && iStart) begin
      r_blk_x0      <= '0;
      r_blk_y0      <= '0;
      r_px          <= '0;
      r_py          <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= iBaseAddr;
      r_row_base    <= iBaseAddr;
      r_blkrow_base <= iBaseAddr;
    end else if (w_fire) begin
      if (!w_px_last) begin
        r_px   <= r_px + LP_ONE_OFS;
        r_x    <= r_x + LP_ONE_DIM;
        r_addr <= r_addr + LP_ONE_ADDR;
      end else if (!w_py_last) begin
        r_px       <= '0;
        r_py       <= r_py + LP_ONE_OFS;
        r_x        <= r_blk_x0;
        r_y        <= r_y + LP_ONE_DIM;
        r_row_base <= w_row_next;
        r_addr     <= w_row_next + {{(P_ADDR_W-P_DIM_W){1'b0}}, r_blk_x0};
      end else if (!w_last_bcol) begin
        r_px       <= '0;
        r_py       <= '0;
        r_blk_x0   <= w_bx_next;
        r_x        <= w_bx_next;
        r_y        <= r_blk_y0;
        r_row_base <= r_blkrow_base;
        r_addr     <= r_blkrow_base + {{(P_ADDR_W-P_DIM_W){1'b0}}, w_bx_next};
      end else if (!w_last_brow) begin
        // Non-final block rows are always full height, so the next block
        // row starts on the line directly below the current one.
        r_px          <= '0;
        r_py          <= '0;
        r_blk_x0      <= '0;
        r_blk_y0      <= r_blk_y0 + w_blk_dim;
        r_x           <= '0;
        r_y           <= r_y + LP_ONE_DIM;
        r_row_base    <= w_row_next;
        r_blkrow_base <= w_row_next;
        r_addr        <= w_row_next;
      end
    end
  end

  assign oBusy                = w_run;
  assign oDone                = (r_state == S_DONE);
  assign addr_if.oAddrValid   = w_run;
  assign addr_if.oAddr        = r_addr;
  assign addr_if.oX           = r_x;
  assign addr_if.oY           = r_y;
  assign addr_if.oFirstInBlk  = w_run && (r_px == '0) && (r_py == '0);
  assign addr_if.oLastInBlk   = w_run && w_px_last && w_py_last;
  assign addr_if.oLastInFrame = w_run && w_last_frame;

endmodule

// File: tb/tb_mblk_scan_addr_gen.sv
// Testbench for mblk_scan_addr_gen. A table of frame configurations is run
// against a nested-loop reference model of macroblock scan order; every
// handshake is compared (address, coordinates, flags), plus start latency,
// done pulse, empty frames, address wrap and asynchronous reset mid-frame.
module tb_mblk_scan_addr_gen;
  localparam int DW = 12;
  localparam int AW = 24;
  localparam longint AMASK = (64'd1 << AW) - 1;

`ifdef MBLK_CLIP_EN
  localparam int CNT_20X12  = 240;
  localparam int CNT_48X40  = 1920;
  localparam int CNT_7X7    = 49;
  localparam int CNT_100X70 = 7000;
`else
  localparam int CNT_20X12  = 128;
  localparam int CNT_48X40  = 1536;
  localparam int CNT_7X7    = 0;
  localparam int CNT_100X70 = 6144;
`endif

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iStart = 1'b0;
  logic [1:0]    iMbType = '0;
  logic [DW-1:0] iFrameW = '0;
  logic [DW-1:0] iFrameH = '0;
  logic [AW-1:0] iStride = '0;
  logic [AW-1:0] iBaseAddr = '0;
  logic          oBusy;
  logic          oDone;

  mblk_scan_addr_gen_if #(.P_DIM_W(DW), .P_ADDR_W(AW)) ifc ();

  mblk_scan_addr_gen #(.P_DIM_W(DW), .P_ADDR_W(AW)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iStart    (iStart),
    .iMbType   (iMbType),
    .iFrameW   (iFrameW),
    .iFrameH   (iFrameH),
    .iStride   (iStride),
    .iBaseAddr (iBaseAddr),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .addr_if   (ifc)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [1:0] t;
    int w, h, stride, base, mode, rst_at, exp_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  logic [AW-1:0] cap_q[$];

  function automatic logic [63:0] pack(input logic [AW-1:0] a, input logic [DW-1:0] x,
                                       input logic [DW-1:0] y, input logic f,
                                       input logic lb, input logic lf);
    return {13'd0, a, x, y, f, lb, lf};
  endfunction

  function automatic logic [63:0] out_word();
    return pack(ifc.oAddr, ifc.oX, ifc.oY, ifc.oFirstInBlk, ifc.oLastInBlk, ifc.oLastInFrame);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: enumerate blocks then pixels with plain arithmetic.
  task automatic build_model(input logic [1:0] t, input int w, input int h,
                             input int stride, input int base);
    int b, nbx, nby, bw, bh, x, y;
    longint a;
    exp_q.delete();
    case (t)
      2'b00: b = 8;
      2'b11: b = 16;
      2'b10: b = 32;
      default: b = 64;
    endcase
`ifdef MBLK_CLIP_EN
    nbx = (w + b - 1) / b;
    nby = (h + b - 1) / b;
`else
    nbx = w / b;
    nby = h / b;
`endif
    for (int by = 0; by < nby; by++) begin
      for (int bx = 0; bx < nbx; bx++) begin
        bw = (w - bx * b < b) ? (w - bx * b) : b;
        bh = (h - by * b < b) ? (h - by * b) : b;
        for (int py = 0; py < bh; py++) begin
          for (int px = 0; px < bw; px++) begin
            x = bx * b + px;
            y = by * b + py;
            a = (longint'(base) + longint'(y) * longint'(stride) + longint'(x)) & AMASK;
            exp_q.push_back(pack(a[AW-1:0], x[DW-1:0], y[DW-1:0],
                                 (px == 0 && py == 0),
                                 (px == bw - 1 && py == bh - 1),
                                 (px == bw - 1 && py == bh - 1 && bx == nbx - 1 && by == nby - 1)));
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, ifc.oAddrValid, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_outs"}, out_word(), 0);
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready random.
  task automatic run_frame(input logic [1:0] t, input int w, input int h, input int stride,
                           input int base, input int mode, input int rst_at, output int n_hs);
    int idx, cyc, limit;
    bit rdy, v;
    logic [AW-1:0] a;
    build_model(t, w, h, stride, base);
    cap_q.delete();
    n_hs = 0;
    @(negedge iClk);
    iMbType = t; iFrameW = w[DW-1:0]; iFrameH = h[DW-1:0];
    iStride = stride[AW-1:0]; iBaseAddr = base[AW-1:0]; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    // Scramble configuration while busy; it must be ignored.
    iMbType = 2'($urandom); iFrameW = DW'($urandom); iFrameH = DW'($urandom);
    iStride = AW'($urandom); iBaseAddr = AW'($urandom);
    if (exp_q.size() == 0) begin
      chk("zero_done", oDone, 1);
      chk("zero_valid", ifc.oAddrValid, 0);
      chk("zero_busy", oBusy, 0);
      @(negedge iClk);
      chk("zero_done_clr", oDone, 0);
      chk("zero_valid2", ifc.oAddrValid, 0);
      $display("frame t=%0d %0dx%0d: empty frame, done pulse only", t, w, h);
      return;
    end
    chk("start_busy", oBusy, 1);
    chk("start_valid", ifc.oAddrValid, 1);
    idx = 0; cyc = 0; limit = exp_q.size() * 4 + 50;
    while (idx < exp_q.size() && cyc < limit) begin
      if (idx == rst_at) begin
        iRstN = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
        @(negedge iClk);
        chk("rst_no_done", oDone, 0);
        chk("rst_idle", oBusy, 0);
        n_hs = idx;
        ifc.iAddrReady = 1'b0;
        $display("frame t=%0d %0dx%0d: reset after %0d addresses", t, w, h, idx);
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ifc.iAddrReady = rdy;
      iStart = (cyc == 7);
      v = ifc.oAddrValid;
      a = ifc.oAddr;
      chk($sformatf("valid_hold%0d", idx), v, 1);
      if (v) chk($sformatf("beat%0d", idx), out_word(), exp_q[idx]);
      @(posedge iClk);
      if (v && rdy) begin
        cap_q.push_back(a);
        idx++;
      end
      @(negedge iClk);
      cyc++;
    end
    iStart = 1'b0;
    ifc.iAddrReady = 1'b0;
    n_hs = idx;
    if (idx < exp_q.size()) begin
      chk("timeout_handshakes", idx, exp_q.size());
      return;
    end
    chk("end_done", oDone, 1);
    chk("end_valid", ifc.oAddrValid, 0);
    chk("end_busy", oBusy, 0);
    @(negedge iClk);
    chk("end_done_clr", oDone, 0);
    $display("frame t=%0d %0dx%0d stride=%0d base=0x%0h: %0d addresses in %0d cycles",
             t, w, h, stride, base, idx, cyc);
  endtask

  vec_t vecs[10];
  int got;

  initial begin
    vecs[0] = '{2'b00, 16, 16, 16, 'h100, 0, -1, 256};
    vecs[1] = '{2'b01, 64, 64, 80, 'h2000, 1, -1, 4096};
    vecs[2] = '{2'b00, 20, 12, 20, 'h40, 2, -1, CNT_20X12};
    vecs[3] = '{2'b00, 0, 16, 16, 'h0, 0, -1, 0};
    vecs[4] = '{2'b10, 32, 32, 32, 'hFFFFF0, 2, -1, 1024};
    vecs[5] = '{2'b00, 16, 16, 16, 'h100, 0, 100, 0};
    vecs[6] = '{2'b00, 16, 16, 16, 'h100, 0, -1, 256};
    vecs[7] = '{2'b11, 48, 40, 64, 'h1234, 2, -1, CNT_48X40};
    vecs[8] = '{2'b00, 7, 7, 7, 'h10, 0, -1, CNT_7X7};
    vecs[9] = '{2'b10, 100, 70, 128, 'h55, 2, -1, CNT_100X70};

    ifc.iAddrReady = 1'b0;
    repeat (3) @(negedge iClk);
    check_reset_outputs("reset");
    iRstN = 1'b1;
    @(negedge iClk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].t, vecs[i].w, vecs[i].h, vecs[i].stride, vecs[i].base,
                vecs[i].mode, vecs[i].rst_at, got);
      if (vecs[i].rst_at < 0) chk($sformatf("count_v%0d", i), got, vecs[i].exp_cnt);
      if (i == 0 && cap_q.size() == 256) begin
        chk("v0_addr0", cap_q[0], 'h100);
        chk("v0_addr1", cap_q[1], 'h101);
        chk("v0_addr2", cap_q[2], 'h102);
        chk("v0_addr3", cap_q[3], 'h103);
        chk("v0_addr9th", cap_q[8], 'h110);
        chk("v0_addr65th", cap_q[64], 'h108);
      end
      if (i == 1 && cap_q.size() == 4096) chk("v1_last_addr", cap_q[4095], 'h2000 + 63 * 80 + 63);
      if (i == 4 && cap_q.size() == 1024) begin
        chk("wrap_top", cap_q[15], 'hFFFFFF);
        chk("wrap_zero", cap_q[16], 'h000000);
      end
    end

    // Random geometries against the model.
    for (int r = 0; r < 4; r++) begin
      int w, h;
      w = $urandom_range(0, 48);
      h = $urandom_range(0, 48);
      run_frame(2'($urandom), w, h, w + $urandom_range(0, 8), $urandom_range(0, 'hFFFFFF), 2, -1, got);
      chk($sformatf("count_rand%0d", r), got, exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
